// File: rtl/mul32_sched_pkg.sv
// Shared types and widths for the mul32 request scheduler.
`timescale 1ns/1ps
package mul32_sched_pkg;

    localparam int unsigned MUL_W  = 32;
    localparam int unsigned PROD_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        BUSY,
        RESP
    } state_e;

endpackage

// File: rtl/mul32_sched_rr_arbiter.sv
// Combinational round-robin arbiter: scans from last+1 upward (mod N), first set bit wins.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int unsigned N   = 2,
    parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx,
    output logic           any
);

    always_comb begin
        int unsigned idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/mul32_sched.sv
// Round-robin scheduler sharing one mul32 datapath among N_REQ requesters,
// with operand latching, stale-done masking and a BUSY timeout.
`timescale 1ns/1ps
module mul32_sched
    import mul32_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned TW     = $clog2(TIMEOUT + 1)
) (
    input  logic                   sys_clk,
    input  logic                   wb_rst_i,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [MUL_W*N_REQ-1:0] req_mc,
    input  logic [MUL_W*N_REQ-1:0] req_mp,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [PROD_W-1:0]      rsp_p,
    output logic                   rsp_err,
    output logic                   mul_start,
    output logic [MUL_W-1:0]       mul_mc,
    output logic [MUL_W-1:0]       mul_mp,
    input  logic [PROD_W-1:0]      mul_p,
    input  logic                   mul_done,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id
);

    state_e              state_q, state_d;
    logic [IDW-1:0]      last_q;
    logic [IDW-1:0]      grant_id_q;
    logic [MUL_W-1:0]    mc_q, mp_q;
    logic                start_q;
    logic [TW-1:0]       tcnt_q;
    logic [PROD_W-1:0]   rsp_p_q;
    logic                rsp_err_q;
    logic [N_REQ-1:0]    rsp_valid_q;

    logic [N_REQ-1:0]    arb_gnt;
    logic [IDW-1:0]      arb_idx;
    logic                arb_any;
    logic                accept;
    logic                timeout;

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_arb (
        .req     (req_valid),
        .last    (last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        timeout   = (tcnt_q == TW'(TIMEOUT - 1));
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_gnt;
                    accept    = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = GUARD;
            // done is deliberately ignored here: it may still be high from the previous op
            GUARD: state_d = BUSY;
            BUSY: begin
                if (mul_done || timeout) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            last_q      <= IDW'(N_REQ - 1);
            grant_id_q  <= '0;
            mc_q        <= '0;
            mp_q        <= '0;
            start_q     <= 1'b0;
            tcnt_q      <= '0;
            rsp_p_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= accept;
            rsp_valid_q <= '0;
            if (accept) begin
                mc_q       <= req_mc[arb_idx*MUL_W +: MUL_W];
                mp_q       <= req_mp[arb_idx*MUL_W +: MUL_W];
                grant_id_q <= arb_idx;
                last_q     <= arb_idx;
            end
            if (state_q == GUARD) begin
                tcnt_q <= '0;
            end else if (state_q == BUSY) begin
                tcnt_q <= tcnt_q + TW'(1);
            end
            if (state_q == BUSY) begin
                if (mul_done) begin
                    rsp_p_q   <= mul_p;
                    rsp_err_q <= 1'b0;
                end else if (timeout) begin
                    rsp_p_q   <= '0;
                    rsp_err_q <= 1'b1;
                end
            end
            if (state_d == RESP) begin
                rsp_valid_q <= N_REQ'(1) << grant_id_q;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_err   = rsp_err_q;
    assign mul_start = start_q;
    assign mul_mc    = mc_q;
    assign mul_mp    = mp_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_mul32_sched.sv
// Directed self-checking bench for mul32_sched with a behavioural mul32 model.
`timescale 1ns/1ps
module tb_mul32_sched;

    localparam int unsigned N_REQ   = 2;
    localparam int unsigned TIMEOUT = 64;

    logic         sys_clk = 1'b0;
    logic         wb_rst_i;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [63:0]  req_mc;
    logic [63:0]  req_mp;
    logic [1:0]   rsp_valid;
    logic [63:0]  rsp_p;
    logic         rsp_err;
    logic         mul_start;
    logic [31:0]  mul_mc;
    logic [31:0]  mul_mp;
    logic [63:0]  mul_p    = 64'h0;
    logic         mul_done = 1'b0;
    logic         busy;
    logic [0:0]   grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    // mul32 model: 0 = done lat cycles after start, 1 = stale done then late done, 2 = never done
    int          model_mode = 0;
    int          model_lat  = 3;
    int          k          = 1000;
    logic [63:0] prod       = 64'h0;

    always #5 sys_clk = ~sys_clk;

    mul32_sched #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sys_clk   (sys_clk),
        .wb_rst_i  (wb_rst_i),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mc    (req_mc),
        .req_mp    (req_mp),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .rsp_err   (rsp_err),
        .mul_start (mul_start),
        .mul_mc    (mul_mc),
        .mul_mp    (mul_mp),
        .mul_p     (mul_p),
        .mul_done  (mul_done),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always @(negedge sys_clk) begin
        if (mul_start) begin
            k    = 0;
            prod = {32'h0, mul_mc} * {32'h0, mul_mp};
        end else if (k < 1000) begin
            k++;
        end
        case (model_mode)
            0: begin
                mul_done = (k >= model_lat);
                mul_p    = mul_done ? prod : 64'h0;
            end
            1: begin
                if (k < 2) begin
                    mul_done = 1'b1;
                    mul_p    = 64'h1234_5678_9ABC_DEF0;
                end else if (k < 7) begin
                    mul_done = 1'b0;
                    mul_p    = 64'h0;
                end else begin
                    mul_done = 1'b1;
                    mul_p    = prod;
                end
            end
            default: begin
                mul_done = 1'b0;
                mul_p    = 64'h0;
            end
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        wb_rst_i = 1'b1;
        repeat (2) @(negedge sys_clk);
        wb_rst_i = 1'b0;
    endtask

    // Called at a negedge with operands set; scrambles operands after accept.
    task automatic run_op(input logic [1:0] vmask, output logic [1:0] rdy, output logic [1:0] v,
                          output logic [63:0] p, output logic e, output int lat,
                          output int starts);
        req_valid = vmask;
        #1;
        rdy = req_ready;
        @(posedge sys_clk);
        #1;
        req_valid = '0;
        req_mc    = {2{32'hDEAD_BEEF}};
        req_mp    = {2{32'hCAFE_F00D}};
        lat    = 0;
        starts = 0;
        v      = '0;
        p      = '0;
        e      = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            lat++;
            if (mul_start) starts++;
            if (rsp_valid != 0) begin
                v = rsp_valid;
                p = rsp_p;
                e = rsp_err;
                break;
            end
        end
        check_eq("rsp_seen", 64'(v != 0), 64'd1);
    endtask

    logic [1:0]  rdy, v;
    logic [63:0] p;
    logic        e;
    int          lat, starts, seen, stray;
    logic [1:0]  exp_v [4];
    logic [63:0] exp_p [4];

    initial begin
        wb_rst_i  = 1'b1;
        req_valid = '0;
        req_mc    = '0;
        req_mp    = '0;
        repeat (2) @(negedge sys_clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_start", 64'(mul_start), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_p", rsp_p, 64'd0);
        check_eq("rst_grant", 64'(grant_id), 64'd0);
        check_eq("rst_mc", 64'(mul_mc), 64'd0);
        wb_rst_i = 1'b0;
        @(negedge sys_clk);

        // 1: single request 3*5, done 3 cycles after start
        model_mode = 0;
        model_lat  = 3;
        req_mc[31:0] = 32'd3;
        req_mp[31:0] = 32'd5;
        run_op(2'b01, rdy, v, p, e, lat, starts);
        check_eq("t1_ready", 64'(rdy), 64'h1);
        check_eq("t1_valid", 64'(v), 64'h1);
        check_eq("t1_p", p, 64'd15);
        check_eq("t1_err", 64'(e), 64'd0);
        check_eq("t1_starts", 64'(starts), 64'd1);
        check_eq("t1_latency", 64'(lat), 64'd5);
        check_eq("t1_mc_hold", 64'(mul_mc), 64'd3);
        check_eq("t1_mp_hold", 64'(mul_mp), 64'd5);
        @(negedge sys_clk);
        check_eq("t1_idle", 64'(busy), 64'd0);
        check_eq("t1_p_hold", rsp_p, 64'd15);

        // 2: both held, grants alternate starting at requester 0
        pulse_reset();
        req_mc = {32'd9, 32'd7};
        req_mp = {32'd11, 32'd6};
        exp_v  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_p  = '{64'd42, 64'd99, 64'd42, 64'd99};
        req_valid = 2'b11;
        seen = 0;
        for (int i = 0; i < 200 && seen < 4; i++) begin
            @(negedge sys_clk);
            if (rsp_valid != 0) begin
                check_eq($sformatf("t2_valid%0d", seen), 64'(rsp_valid), 64'(exp_v[seen]));
                check_eq($sformatf("t2_p%0d", seen), rsp_p, exp_p[seen]);
                seen++;
                if (seen == 4) req_valid = '0;
            end
        end
        check_eq("t2_count", 64'(seen), 64'd4);
        @(negedge sys_clk);

        // 3: max operands; last owner was 1, so 0 wins
        req_mc[31:0] = 32'hFFFF_FFFF;
        req_mp[31:0] = 32'hFFFF_FFFF;
        run_op(2'b01, rdy, v, p, e, lat, starts);
        check_eq("t3_valid", 64'(v), 64'h1);
        check_eq("t3_p", p, 64'hFFFF_FFFE_0000_0001);
        @(negedge sys_clk);

        // 4: stale done through ISSUE/GUARD, real done after 5 low BUSY cycles
        model_mode = 1;
        req_mc[63:32] = 32'd1000;
        req_mp[63:32] = 32'd1000;
        run_op(2'b10, rdy, v, p, e, lat, starts);
        check_eq("t4_ready", 64'(rdy), 64'h2);
        check_eq("t4_valid", 64'(v), 64'h2);
        check_eq("t4_p", p, 64'd1000000);
        check_eq("t4_err", 64'(e), 64'd0);
        check_eq("t4_latency", 64'(lat), 64'd9);
        repeat (3) @(negedge sys_clk);
        check_eq("t4_p_hold", rsp_p, 64'd1000000);

        // 5: done never rises -> timeout after 64 BUSY cycles
        model_mode = 2;
        req_mc[31:0] = 32'd2;
        req_mp[31:0] = 32'd2;
        run_op(2'b01, rdy, v, p, e, lat, starts);
        check_eq("t5_valid", 64'(v), 64'h1);
        check_eq("t5_err", 64'(e), 64'd1);
        check_eq("t5_p", p, 64'd0);
        check_eq("t5_latency", 64'(lat), 64'd67);
        @(negedge sys_clk);
        check_eq("t5_idle", 64'(busy), 64'd0);
        check_eq("t5_err_hold", 64'(rsp_err), 64'd1);

        // 6: reset while BUSY
        model_mode = 0;
        model_lat  = 20;
        req_mc = {32'd4, 32'd6};
        req_mp = {32'd4, 32'd7};
        req_valid = 2'b10;
        @(posedge sys_clk);
        #1;
        req_valid = '0;
        repeat (4) @(negedge sys_clk);
        check_eq("t6_busy_pre", 64'(busy), 64'd1);
        check_eq("t6_grant_pre", 64'(grant_id), 64'd1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check_eq("t6_busy", 64'(busy), 64'd0);
        check_eq("t6_mc", 64'(mul_mc), 64'd0);
        check_eq("t6_grant", 64'(grant_id), 64'd0);
        check_eq("t6_rsp_p", rsp_p, 64'd0);
        check_eq("t6_err", 64'(rsp_err), 64'd0);
        @(negedge sys_clk);
        wb_rst_i = 1'b0;
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge sys_clk);
            if (rsp_valid != 0) stray++;
        end
        check_eq("t6_no_rsp", 64'(stray), 64'd0);
        model_lat = 3;
        run_op(2'b11, rdy, v, p, e, lat, starts);
        check_eq("t6_ready", 64'(rdy), 64'h1);
        check_eq("t6_valid", 64'(v), 64'h1);
        check_eq("t6_p", p, 64'd42);
        @(negedge sys_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
